// File: rtl/mda_pkg.sv
// Shared constants, cell-control record and attribute decode helpers for the
// MDA character attribute/dot shifter.
package mda_pkg;

    localparam logic [7:0]  ATTR_MASK      = 8'h77;
    localparam logic [7:0]  ATTR_BLANK     = 8'h00;
    localparam logic [2:0]  ATTR_NORMAL_UL = 3'b001;
    localparam logic [7:0]  ATTR_REVERSE   = 8'h70;
    localparam logic [7:0]  LINE_GFX_LO    = 8'hC0;
    localparam logic [7:0]  LINE_GFX_HI    = 8'hDF;
    localparam int unsigned CELL_DOTS      = 9;
    localparam int unsigned CHAR_ROWS      = 14;

    localparam int unsigned DOT_CNT_W = $clog2(CELL_DOTS + 1);
    localparam int unsigned ROW_W     = $clog2(CHAR_ROWS);

    typedef enum logic [1:0] {
        ATTR_KIND_NORMAL,
        ATTR_KIND_BLANK,
        ATTR_KIND_REVERSE
    } attr_kind_t;

    typedef struct packed {
        logic [7:0]       attr;
        logic [ROW_W-1:0] row;
        logic             cursor;
        logic             de;
        logic             line_gfx;
    } cell_ctrl_t;

    function automatic attr_kind_t attr_kind(input logic [7:0] attr);
        if ((attr & ATTR_MASK) == ATTR_BLANK) begin
            return ATTR_KIND_BLANK;
        end
        if ((attr & ATTR_MASK) == ATTR_REVERSE) begin
            return ATTR_KIND_REVERSE;
        end
        return ATTR_KIND_NORMAL;
    endfunction

    function automatic logic is_line_gfx(input logic [7:0] code);
        return (code >= LINE_GFX_LO) && (code <= LINE_GFX_HI);
    endfunction

endpackage

// File: rtl/mda_blink_counter.sv
// Frame counter advanced on each vsync rising edge; supplies the cursor and
// character blink phases.
module mda_blink_counter (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync_i,
    output logic cursor_phase_o,
    output logic blink_phase_o
);

    logic       vsync_q;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (vsync_i && !vsync_q) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            vsync_q <= vsync_i;
            cnt_q   <= cnt_d;
        end
    end

    // Cursor toggles every 8 frames, character blink every 16.
    assign cursor_phase_o = cnt_q[3];
    assign blink_phase_o  = cnt_q[4];

endmodule

// File: rtl/mda_attr_shifter.sv
// MDA cell renderer: issues font ROM lookups, applies attribute rules and
// serializes 9 dots per character cell at one dot per clock.
module mda_attr_shifter
    import mda_pkg::*;
#(
    parameter int unsigned FONT_LATENCY = 2,
    parameter int unsigned UL_ROW       = 12,
    parameter logic        LINE_GFX_EN  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_load,
    input  logic [7:0] char_code,
    input  logic [7:0] char_attr,
    input  logic [3:0] char_row,
    input  logic       cursor_here,
    input  logic [3:0] cursor_start,
    input  logic [3:0] cursor_end,
    input  logic       de_in,
    input  logic       vsync,
    output logic [7:0] font_code,
    output logic [3:0] font_row,
    input  logic [7:0] font_data,
    output logic       video,
    output logic       intense,
    output logic       de_out
);

    localparam logic [ROW_W-1:0] UL_ROW_V = ROW_W'(UL_ROW);

    logic [7:0]          font_code_q;
    logic [3:0]          font_row_q;
    cell_ctrl_t          pipe_q [FONT_LATENCY+1];
    logic [FONT_LATENCY:0] vld_q;

    logic                cursor_phase;
    logic                blink_phase;

    cell_ctrl_t          ctl;
    attr_kind_t          kind;
    logic                on_ul;
    logic                on_cursor;
    logic [CELL_DOTS-1:0] cell_dots;
    logic                cell_intense;

    logic [CELL_DOTS-1:0] shift_q, shift_d;
    logic [DOT_CNT_W-1:0] left_q, left_d;
    logic                cell_de_q, cell_de_d;
    logic                cell_int_q, cell_int_d;
    logic                active;
    logic                video_q, video_d;
    logic                intense_q, intense_d;
    logic                de_out_q, de_out_d;

    mda_blink_counter u_blink (
        .clk_i          (clk),
        .rst_i          (rst),
        .vsync_i        (vsync),
        .cursor_phase_o (cursor_phase),
        .blink_phase_o  (blink_phase)
    );

    // Control fields ride alongside the ROM access so they meet font_data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            font_code_q <= '0;
            font_row_q  <= '0;
            vld_q       <= '0;
            for (int unsigned i = 0; i <= FONT_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= char_load;
            if (char_load) begin
                font_code_q        <= char_code;
                font_row_q         <= char_row;
                pipe_q[0].attr     <= char_attr;
                pipe_q[0].row      <= char_row;
                pipe_q[0].cursor   <= cursor_here;
                pipe_q[0].de       <= de_in;
                pipe_q[0].line_gfx <= LINE_GFX_EN & is_line_gfx(char_code);
            end
            for (int unsigned i = 1; i <= FONT_LATENCY; i++) begin
                vld_q[i]  <= vld_q[i-1];
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    always_comb begin
        ctl          = pipe_q[FONT_LATENCY];
        kind         = attr_kind(ctl.attr);
        on_ul        = (ctl.attr[2:0] == ATTR_NORMAL_UL) && (ctl.row == UL_ROW_V);
        on_cursor    = ctl.cursor && (cursor_start <= ctl.row) &&
                       (ctl.row <= cursor_end) && cursor_phase;
        cell_dots    = {font_data, ctl.line_gfx & font_data[0]};
        // Later rules deliberately override earlier ones; cursor wins.
        if (on_ul) begin
            cell_dots = '1;
        end
        if (kind == ATTR_KIND_BLANK) begin
            cell_dots = '0;
        end
        if (kind == ATTR_KIND_REVERSE) begin
            cell_dots = ~cell_dots;
        end
        if (ctl.attr[7] && !blink_phase) begin
            cell_dots = '0;
        end
        if (on_cursor) begin
            cell_dots = '1;
        end
        if (!ctl.de) begin
            cell_dots = '0;
        end
        cell_intense = ctl.de & ctl.attr[3] & (kind != ATTR_KIND_REVERSE);
    end

    always_comb begin
        active     = (left_q != '0);
        video_d    = shift_q[CELL_DOTS-1] & active;
        intense_d  = cell_int_q & active;
        de_out_d   = cell_de_q & active;
        shift_d    = shift_q;
        left_d     = left_q;
        cell_de_d  = cell_de_q;
        cell_int_d = cell_int_q;
        // A new cell preempts whatever dots of the previous one remain.
        if (vld_q[FONT_LATENCY]) begin
            shift_d    = cell_dots;
            left_d     = DOT_CNT_W'(CELL_DOTS);
            cell_de_d  = ctl.de;
            cell_int_d = cell_intense;
        end else if (active) begin
            shift_d = {shift_q[CELL_DOTS-2:0], 1'b0};
            left_d  = left_q - DOT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            left_q     <= '0;
            cell_de_q  <= 1'b0;
            cell_int_q <= 1'b0;
            video_q    <= 1'b0;
            intense_q  <= 1'b0;
            de_out_q   <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            left_q     <= left_d;
            cell_de_q  <= cell_de_d;
            cell_int_q <= cell_int_d;
            video_q    <= video_d;
            intense_q  <= intense_d;
            de_out_q   <= de_out_d;
        end
    end

    assign font_code = font_code_q;
    assign font_row  = font_row_q;
    assign video     = video_q;
    assign intense   = intense_q;
    assign de_out    = de_out_q;

endmodule
